// File: rtl/bram_sdp_emu_if.sv
// Port bundle for the simple-dual-port RAM emulator.
// master drives the request side; slave is the RAM.
interface bram_sdp_emu_if #(
    parameter int unsigned DATA_WIDTH = 18,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned WE_WIDTH   = 2
);
    logic                  init_busy;
    logic                  read_en;
    logic [ADDR_WIDTH-1:0] read_addr;
    logic [DATA_WIDTH-1:0] read_data;
    logic                  read_valid;
    logic                  read_collision;
    logic [WE_WIDTH-1:0]   write_en;
    logic [ADDR_WIDTH-1:0] write_addr;
    logic [DATA_WIDTH-1:0] write_data;

    modport master (
        output read_en, read_addr, write_en, write_addr, write_data,
        input  init_busy, read_data, read_valid, read_collision
    );

    modport slave (
        input  read_en, read_addr, write_en, write_addr, write_data,
        output init_busy, read_data, read_valid, read_collision
    );
endinterface

// File: rtl/bram_sdp_emu.sv
// Parametrised simple-dual-port block RAM emulator with lane write enables,
// selectable read-during-write behaviour, optional output register and clear sweep.
module bram_sdp_emu #(
    parameter int unsigned DATA_WIDTH = 18,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned WE_WIDTH   = 2,
    parameter int unsigned OUT_REG    = 0,
    parameter int unsigned RDW_MODE   = 0,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic               clk,
    input  logic               rst,
    bram_sdp_emu_if.slave      bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned LANE  = DATA_WIDTH / WE_WIDTH;

    if ((DATA_WIDTH % WE_WIDTH) != 0 || RDW_MODE > 2) begin : g_bad_param
        $error("bram_sdp_emu: DATA_WIDTH must divide by WE_WIDTH and RDW_MODE must be 0..2");
    end

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_busy;
    logic [ADDR_WIDTH-1:0] r_clr_addr;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                  w_clr_we;
    logic                  w_rd_fire;
    logic                  w_wr_fire;
    logic                  w_coll;
    logic                  w_rd_keep;
    logic [DATA_WIDTH-1:0] w_rd_old;
    logic [DATA_WIDTH-1:0] w_wr_old;
    logic [DATA_WIDTH-1:0] w_wr_merged;
    logic [DATA_WIDTH-1:0] w_rd_word;

    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_rd_valid;
    logic                  r_rd_coll;

    // State register, clear-address counter and busy flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_CLEAR;
            r_busy     <= 1'b1;
            r_clr_addr <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == ST_CLEAR);
            if (w_clr_we) begin
                r_clr_addr <= r_clr_addr + ADDR_WIDTH'(1);
            end
        end
    end

    // Next state and port qualification; ports are dead while clearing or in reset
    always_comb begin
        w_state_nxt = r_state;
        w_clr_we    = 1'b0;
        w_rd_fire   = 1'b0;
        w_wr_fire   = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                w_clr_we = 1'b1;
                if (r_clr_addr == ADDR_WIDTH'(DEPTH - 1)) begin
                    w_state_nxt = ST_READY;
                end
            end
            ST_READY: begin
                w_rd_fire = bus.read_en;
                w_wr_fire = |bus.write_en;
            end
            default: w_state_nxt = ST_CLEAR;
        endcase
        if (rst) begin
            w_state_nxt = ST_CLEAR;
            w_clr_we    = 1'b0;
            w_rd_fire   = 1'b0;
            w_wr_fire   = 1'b0;
        end
    end

    assign w_rd_old = r_mem[bus.read_addr];
    assign w_wr_old = r_mem[bus.write_addr];
    assign w_coll   = w_rd_fire & w_wr_fire & (bus.read_addr == bus.write_addr);

    // Disabled lanes keep the stored word, so a write is a read-modify-write
    for (genvar g = 0; g < WE_WIDTH; g++) begin : g_lane
        assign w_wr_merged[g*LANE +: LANE] = bus.write_en[g] ? bus.write_data[g*LANE +: LANE]
                                                             : w_wr_old[g*LANE +: LANE];
    end

    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[r_clr_addr] <= CLEAR_VALUE;
        end else if (w_wr_fire) begin
            r_mem[bus.write_addr] <= w_wr_merged;
        end
    end

    // Read-during-write selection on a same-address collision
    always_comb begin
        w_rd_word = w_rd_old;
        w_rd_keep = 1'b0;
        if (w_coll) begin
            if (RDW_MODE == 1) begin
                w_rd_word = w_wr_merged;
            end else if (RDW_MODE == 2) begin
                w_rd_keep = 1'b1;
            end
        end
    end

    if (OUT_REG == 0) begin : g_lat1
        always_ff @(posedge clk) begin
            if (rst) begin
                r_rd_data  <= '0;
                r_rd_valid <= 1'b0;
                r_rd_coll  <= 1'b0;
            end else begin
                r_rd_valid <= w_rd_fire;
                r_rd_coll  <= w_coll;
                if (w_rd_fire && !w_rd_keep) begin
                    r_rd_data <= w_rd_word;
                end
            end
        end
    end else begin : g_lat2
        logic                  r_s1_valid;
        logic                  r_s1_coll;
        logic                  r_s1_keep;
        logic [DATA_WIDTH-1:0] r_s1_data;

        // Extra stage; a held (NO_CHANGE) result is resolved at the output register
        always_ff @(posedge clk) begin
            if (rst) begin
                r_s1_valid <= 1'b0;
                r_s1_coll  <= 1'b0;
                r_s1_keep  <= 1'b0;
                r_s1_data  <= '0;
                r_rd_data  <= '0;
                r_rd_valid <= 1'b0;
                r_rd_coll  <= 1'b0;
            end else begin
                r_s1_valid <= w_rd_fire;
                r_s1_coll  <= w_coll;
                r_s1_keep  <= w_rd_keep;
                r_s1_data  <= w_rd_word;
                r_rd_valid <= r_s1_valid;
                r_rd_coll  <= r_s1_valid & r_s1_coll;
                if (r_s1_valid && !r_s1_keep) begin
                    r_rd_data <= r_s1_data;
                end
            end
        end
    end

    assign bus.init_busy      = r_busy;
    assign bus.read_data      = r_rd_data;
    assign bus.read_valid     = r_rd_valid;
    assign bus.read_collision = r_rd_coll;
endmodule

// File: doc/bram_sdp_emu.md
Name: bram_sdp_emu

Overview:
Parametrised simple-dual-port block RAM emulator. It is the successor to the fixed 1k x 18 emulator and adds configurable width and depth, per-lane write enables, read enable with a valid strobe, an optional output register, a selectable read-during-write mode, and a reset-driven clear sequencer. It sits wherever convolution buffers need on-chip storage in simulation, and its interface maps onto a vendor SDP macro.

Parameters:
DATA_WIDTH, 18, word width in bits; must be divisible by WE_WIDTH.
ADDR_WIDTH, 10, address width; depth is 2**ADDR_WIDTH.
WE_WIDTH, 2, number of write lanes; lane width LANE = DATA_WIDTH/WE_WIDTH.
OUT_REG, 0, 0 gives read latency 1; 1 adds an output register for read latency 2.
RDW_MODE, 0, read-during-write on the same address: 0 READ_FIRST, 1 WRITE_FIRST, 2 NO_CHANGE.
CLEAR_VALUE, 0, word written to every location by the clear sequence.

Ports:
clk  in  1  clock; all logic on rising edge.
rst  in  1  synchronous, active-high reset.
init_busy  out  1  high while the clear sequence runs.
read_en  in  1  read request.
read_addr  in  ADDR_WIDTH  read address.
read_data  out  DATA_WIDTH  read result.
read_valid  out  1  one-cycle strobe, aligned with the corresponding read_data.
read_collision  out  1  aligned with read_valid; high if that read collided with a write.
write_en  in  WE_WIDTH  per-lane write enable; bit i covers data bits [i*LANE +: LANE].
write_addr  in  ADDR_WIDTH  write address.
write_data  in  DATA_WIDTH  write data.

Behaviour:
- Reset values:
  - While rst is high: read_data=0, read_valid=0, read_collision=0, init_busy=1, clear address=0.
  - The pipeline stage registers (OUT_REG=1) are also zeroed.
- FSM state CLEAR (entered on rst):
  - Each cycle writes CLEAR_VALUE to the clear address, then increments it.
  - After address 2**ADDR_WIDTH-1 is written, moves to READY.
  - init_busy falls on the first cycle after rst deasserts plus 2**ADDR_WIDTH cycles; it is low in that cycle.
  - In CLEAR, read_en and write_en are ignored: no memory update from ports, no read_valid.
  - rst asserted mid-clear restarts the sweep at address 0.
- FSM state READY:
  - Normal operation. Only rst leaves this state.
- Write timing:
  - At a clock edge with any write_en bit high, the lanes whose enable bit is set take write_data.
  - Lanes with a clear enable bit keep their contents.
  - write_en=0 means no change.
- Read timing:
  - read_en high at edge t (READY): the memory word is sampled at t.
  - OUT_REG=0: read_data and read_valid update at edge t. OUT_REG=1: they update at edge t+1.
  - read_valid is high for exactly one cycle per accepted read. Back-to-back reads give back-to-back valids at full throughput.
- read_data retention:
  - Holds its last value when no read completes; it does not return to 0.
- Collision (read_en, any write_en bit, read_addr==write_addr, same edge):
  - read_collision=1 alongside the read's read_valid.
  - READ_FIRST: returns the pre-write word.
  - WRITE_FIRST: returns the merged word, i.e. enabled lanes from write_data and the other lanes from the old word.
  - NO_CHANGE: read_data keeps its previous value; read_valid still pulses.
  - In every mode the memory is updated as for a normal write.
- Non-colliding simultaneous read and write: independent, no interaction.
- Addresses are always in range because depth is 2**ADDR_WIDTH; no wrap logic is needed beyond natural width.
- Parameter check: an elaboration-time error if DATA_WIDTH % WE_WIDTH != 0 or RDW_MODE > 2.
- RTL size target: about 150-250 lines, with generate blocks for the OUT_REG and lane logic.

Test Plan:
- Clear sequence (ADDR_WIDTH=4, CLEAR_VALUE=18'h2A5):
  - Pulse rst for 1 cycle -> init_busy high for exactly 16 cycles.
  - Then reading all 16 addresses returns 18'h2A5 each.
  - A write issued during busy has no effect.
- Latency:
  - OUT_REG=0: read_en at cycle 5 to addr 3 (holding 18'h1234) -> read_data=18'h1234 and read_valid=1 after edge 5 only.
  - OUT_REG=1: the same values appear one cycle later.
  - 8 consecutive reads -> 8 consecutive valids.
- Lane writes (WE_WIDTH=2, LANE=9):
  - Addr 7 holds 18'h3FFFF; write 18'h00000 with write_en=2'b01 -> read gives 18'h3FE00.
  - Then write_en=2'b10 -> read gives 18'h00000.
- Collision:
  - Addr 9 holds 18'h00011; same-edge read and write of 18'h3F0F0 with write_en=2'b11.
  - Mode 0 returns 18'h00011, mode 1 returns 18'h3F0F0, mode 2 keeps the prior read_data.
  - In all modes read_collision=1, and a later read returns 18'h3F0F0.
- Reset mid-operation:
  - Assert rst mid-clear (address 10) -> the sweep restarts from 0, busy lasts the full 16 cycles again.
  - Assert rst with a read in flight (OUT_REG=1) -> no read_valid emerges and read_data=0.
- Width sweep: DATA_WIDTH=32, ADDR_WIDTH=9, WE_WIDTH=4 -> random writes and reads match a scoreboard model across 2000 cycles.
